// File: rtl/dual_port_ram.sv
// 256x4 single-clock scratch RAM: shared address, write/read strobes gated by chip select, registered read data.
// Optional build macro RAM_WRITE_THROUGH_EN forwards data_in to data_out when write and read coincide.
module dual_port_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chip_selection,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_IDLE       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_READ       = 2'd2,
    OP_WRITE_READ = 2'd3
  } op_t;

  // Power-up contents are zero so unwritten locations read back as 0.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_data_out;
  op_t                   w_op;
  logic                  w_mem_we;

  // Decode the access requested this cycle; write takes priority over read.
  always_comb begin
    w_op = OP_IDLE;
    if (!chip_selection) begin
      w_op = OP_IDLE;
    end else if (write && read) begin
      w_op = OP_WRITE_READ;
    end else if (write) begin
      w_op = OP_WRITE;
    end else if (read) begin
      w_op = OP_READ;
    end else begin
      w_op = OP_IDLE;
    end
  end

  // Memory write enable derived from the decoded access.
  always_comb begin
    w_mem_we = 1'b0;
    case (w_op)
      OP_WRITE:      w_mem_we = 1'b1;
      OP_WRITE_READ: w_mem_we = 1'b1;
      OP_READ:       w_mem_we = 1'b0;
      default:       w_mem_we = 1'b0;
    endcase
  end

  // Storage array; reset leaves contents intact but blocks writes on that edge.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      r_mem[address] <= data_in;
    end
  end

  // Registered read port; holds unless a read (or forwarded write) occurs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else begin
      case (w_op)
        OP_READ: r_data_out <= r_mem[address];
`ifdef RAM_WRITE_THROUGH_EN
        OP_WRITE_READ: r_data_out <= data_in;
`else
        OP_WRITE_READ: r_data_out <= r_data_out;
`endif
        default: r_data_out <= r_data_out;
      endcase
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: per-scenario stimulus tables with a queue of expected data_out values.
module tb_dual_port_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       chip_selection;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [3:0] data_in;
  logic [3:0] data_out;

  typedef struct {
    logic       rst_n;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [3:0] din;
  } step_t;

  step_t      stim_q[$];
  logic [3:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;

  dual_port_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .chip_selection(chip_selection), .write(write),
    .read(read), .address(address), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic push(input logic r, input logic cs, input logic wr, input logic rd,
                      input logic [7:0] a, input logic [3:0] d, input logic [3:0] exp);
    step_t s;
    s.rst_n = r; s.cs = cs; s.wr = wr; s.rd = rd; s.addr = a; s.din = d;
    stim_q.push_back(s);
    sb_q.push_back(exp);
  endtask

  task automatic step(input step_t s);
    rst_n = s.rst_n; chip_selection = s.cs; write = s.wr; read = s.rd;
    address = s.addr; data_in = s.din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s; logic [3:0] e;
    push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    push(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 4'h9, 4'h0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 4'h0, 4'h0);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 4'h0, 4'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL reset addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  task automatic test_write_read();
    step_t s; logic [3:0] e;
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 4'b0001, 4'h0);
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 4'b0010, 4'h0);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 4'h0, 4'b0001);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 4'h0, 4'b0010);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL write_read addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  task automatic test_chip_deselect();
    step_t s; logic [3:0] e;
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'hA, 4'h2);
    push(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 4'h3, 4'h2);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 4'h0, 4'hA);
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 4'h0, 4'hA);
    push(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 4'h5, 4'hA);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 4'h0, 4'h2);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 4'h0, 4'hA);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL chip_deselect addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  task automatic test_hold();
    step_t s; logic [3:0] e;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 1'b1, 1'b0, 1'b0, 8'(i * 37 + 1), 4'(i), 4'hA);
    end
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'h30, 4'h5, 4'hA);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 4'h0, 4'h5);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL hold addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s; logic [3:0] e;
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 4'h0, 4'h1);
`ifdef RAM_WRITE_THROUGH_EN
    push(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 4'h7, 4'h7);
`else
    push(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 4'h7, 4'h1);
`endif
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 4'h0, 4'h7);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL simultaneous addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  task automatic test_boundary_reset();
    step_t s; logic [3:0] e;
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'hF, 4'h7);
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'hC, 4'h7);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 4'hF);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 4'h0, 4'hC);
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0);
    push(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 4'h3, 4'h0);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 4'h0, 4'hC);
    push(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 4'hF);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); step(s); e = sb_q.pop_front(); checks++;
      if (data_out !== e) begin
        errors++; $display("FAIL boundary_reset addr=%h: data_out=%h expected %h", s.addr, data_out, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; chip_selection = 1'b0; write = 1'b0; read = 1'b0;
    address = 8'h00; data_in = 4'h0;
    test_reset();
    test_write_read();
    test_chip_deselect();
    test_hold();
    test_simultaneous();
    test_boundary_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
